// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package rv_ctrl_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StDecode,
    StExecute,
    StTrap
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/rv_decode.sv
// Combinational instruction classifier for the supported RV32I subset.
module rv_decode
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned D_WIDTH = 32
) (
  input  logic [31:0]        ir,
  output logic               legal,
  output logic               ALUsrc,
  output logic [2:0]         ALUctrl,
  output logic               reg_wr,
  output logic               is_branch,
  output logic               br_ne,
  output logic [D_WIDTH-1:0] ImmOp,
  output logic [A_WIDTH-1:0] rs1,
  output logic [A_WIDTH-1:0] rs2,
  output logic [A_WIDTH-1:0] rd
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign rd     = ir[7 +: A_WIDTH];
  assign rs1    = ir[15 +: A_WIDTH];
  assign rs2    = ir[20 +: A_WIDTH];

  // Classify opcode/funct fields; illegal encodings leave all controls at zero.
  always_comb begin
    legal     = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    reg_wr    = 1'b0;
    is_branch = 1'b0;
    br_ne     = 1'b0;
    ImmOp     = '0;
    unique case (opcode)
      OPC_OP: begin
        legal  = 1'b1;
        reg_wr = 1'b1;
        if (f3 == 3'b000 && f7 == 7'b0000000)      ALUctrl = ALU_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) ALUctrl = ALU_SUB;
        else if (f3 == 3'b111 && f7 == 7'b0000000) ALUctrl = ALU_AND;
        else if (f3 == 3'b110 && f7 == 7'b0000000) ALUctrl = ALU_OR;
        else if (f3 == 3'b010 && f7 == 7'b0000000) ALUctrl = ALU_SLT;
        else begin
          legal  = 1'b0;
          reg_wr = 1'b0;
        end
      end
      OPC_OPIMM: begin
        legal  = 1'b1;
        reg_wr = 1'b1;
        ALUsrc = 1'b1;
        ImmOp  = {{(D_WIDTH-12){ir[31]}}, ir[31:20]};
        unique case (f3)
          3'b000:  ALUctrl = ALU_ADD;
          3'b111:  ALUctrl = ALU_AND;
          3'b110:  ALUctrl = ALU_OR;
          3'b010:  ALUctrl = ALU_SLT;
          default: begin
            legal  = 1'b0;
            reg_wr = 1'b0;
            ALUsrc = 1'b0;
            ImmOp  = '0;
          end
        endcase
      end
      OPC_BRANCH: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          legal     = 1'b1;
          is_branch = 1'b1;
          br_ne     = f3[0];
          ALUctrl   = ALU_SUB;
          ImmOp     = {{(D_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer owning the PC and instruction register.
module rv_mc_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned     A_WIDTH  = 5,
  parameter int unsigned     D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [D_WIDTH-1:0] imem_rdata,
  input  logic               EQ,
  output logic               ALUsrc,
  output logic [2:0]         ALUctrl,
  output logic               RegWrite,
  output logic [A_WIDTH-1:0] rs1,
  output logic [A_WIDTH-1:0] rs2,
  output logic [A_WIDTH-1:0] rd,
  output logic [D_WIDTH-1:0] ImmOp,
  output logic [D_WIDTH-1:0] pc,
  output logic               trap
);

  state_e             state_q, state_d;
  logic [D_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;

  logic               legal, reg_wr, is_branch, br_ne, taken;
  logic [D_WIDTH-1:0] target;

  rv_decode #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_decode (
    .ir        (ir_q),
    .legal     (legal),
    .ALUsrc    (ALUsrc),
    .ALUctrl   (ALUctrl),
    .reg_wr    (reg_wr),
    .is_branch (is_branch),
    .br_ne     (br_ne),
    .ImmOp     (ImmOp),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  assign taken  = is_branch && (br_ne ? !EQ : EQ);
  assign target = pc_q + ImmOp;

  // State, PC and IR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC/IR update and handshake/write outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    RegWrite = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      StFetch: begin
        // Gated by rst_n so no request is seen while reset is held.
        imem_req = rst_n;
        if (imem_valid) begin
          ir_d    = imem_rdata[31:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = legal ? StExecute : StTrap;
      end
      StExecute: begin
        RegWrite = reg_wr && (rd != '0);
        state_d  = StFetch;
        if (taken) begin
          // Misaligned target traps with the PC left on the branch.
          if (target[1:0] != 2'b00) state_d = StTrap;
          else                      pc_d    = target;
        end else begin
          pc_d = pc_q + D_WIDTH'(4);
        end
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: state_d = StTrap;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl with hand-computed expectations.
module tb_rv_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        EQ;
  logic        ALUsrc;
  logic [2:0]  ALUctrl;
  logic        RegWrite;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic [31:0] pc;
  logic        trap;

  int n_checks = 0;
  int n_pass   = 0;

  rv_mc_ctrl #(
    .A_WIDTH  (5),
    .D_WIDTH  (32),
    .PC_RESET (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .EQ         (EQ),
    .ALUsrc     (ALUsrc),
    .ALUctrl    (ALUctrl),
    .RegWrite   (RegWrite),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .ImmOp      (ImmOp),
    .pc         (pc),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle at address addr: wait cycles, deliver instr, land in EXECUTE.
  task automatic issue(input logic [31:0] instr, input logic [31:0] addr, input int waits);
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      step();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, addr);
      check("wait_nowr", {31'b0, RegWrite}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    step();
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("dec_nowr", {31'b0, RegWrite}, 32'd0);
    check("dec_noreq", {31'b0, imem_req}, 32'd0);
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    EQ         = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_wr", {31'b0, RegWrite}, 32'd0);
    check("rst_alusrc", {31'b0, ALUsrc}, 32'd0);
    check("rst_aluctrl", {29'b0, ALUctrl}, 32'd0);
    check("rst_imm", ImmOp, 32'd0);
    check("rst_rd", {27'b0, rd}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    #1;

    // addi x1,x0,5 with no fetch wait
    issue(32'h0050_0093, 32'h0, 0);
    check("addi_wr", {31'b0, RegWrite}, 32'd1);
    check("addi_rd", {27'b0, rd}, 32'd1);
    check("addi_rs1", {27'b0, rs1}, 32'd0);
    check("addi_src", {31'b0, ALUsrc}, 32'd1);
    check("addi_ctrl", {29'b0, ALUctrl}, 32'b000);
    check("addi_imm", ImmOp, 32'd5);
    step();
    check("addi_next", imem_addr, 32'h4);
    check("addi_nowr", {31'b0, RegWrite}, 32'd0);

    // sub x2,x1,x2
    issue(32'h4020_8133, 32'h4, 0);
    check("sub_src", {31'b0, ALUsrc}, 32'd0);
    check("sub_ctrl", {29'b0, ALUctrl}, 32'b001);
    check("sub_rs1", {27'b0, rs1}, 32'd1);
    check("sub_rs2", {27'b0, rs2}, 32'd2);
    check("sub_rd", {27'b0, rd}, 32'd2);
    check("sub_wr", {31'b0, RegWrite}, 32'd1);
    step();

    // ori x3,x0,-1 then and x4,x1,x2 to reach pc=0x10
    issue(32'hFFF0_6193, 32'h8, 0);
    check("ori_ctrl", {29'b0, ALUctrl}, 32'b011);
    check("ori_imm", ImmOp, 32'hFFFF_FFFF);
    step();
    issue(32'h0020_F233, 32'hC, 0);
    check("and_ctrl", {29'b0, ALUctrl}, 32'b010);
    step();

    // beq x0,x0,+8 taken
    issue(32'h0000_0463, 32'h10, 0);
    EQ = 1'b1;
    #1;
    check("beq_wr", {31'b0, RegWrite}, 32'd0);
    check("beq_imm", ImmOp, 32'd8);
    check("beq_ctrl", {29'b0, ALUctrl}, 32'b001);
    check("beq_src", {31'b0, ALUsrc}, 32'd0);
    step();
    EQ = 1'b0;
    check("beq_taken", imem_addr, 32'h18);

    // beq not taken
    issue(32'h0000_0463, 32'h18, 0);
    EQ = 1'b0;
    step();
    check("beq_fall", imem_addr, 32'h1C);

    // addi x1 with three fetch wait cycles
    issue(32'h0050_0093, 32'h1C, 3);
    check("wait_exec_wr", {31'b0, RegWrite}, 32'd1);
    step();
    check("wait_next", imem_addr, 32'h20);

    // addi x0: no write
    issue(32'h0050_0013, 32'h20, 0);
    check("rd0_nowr", {31'b0, RegWrite}, 32'd0);
    step();

    // bne x0,x0,+8 with EQ=0 taken
    issue(32'h0000_1463, 32'h24, 0);
    EQ = 1'b0;
    step();
    check("bne_taken", imem_addr, 32'h2C);

    // beq +2 taken: misaligned target traps, PC kept
    issue(32'h0000_0163, 32'h2C, 0);
    EQ = 1'b1;
    step();
    EQ = 1'b0;
    check("mis_trap", {31'b0, trap}, 32'd1);
    check("mis_req", {31'b0, imem_req}, 32'd0);
    check("mis_pc", pc, 32'h2C);

    rst_n = 1'b0;
    #1;
    check("rst2_trap", {31'b0, trap}, 32'd0);
    check("rst2_req", {31'b0, imem_req}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("rst2_addr", imem_addr, 32'h0);

    // all-zero word is illegal
    imem_valid = 1'b1;
    imem_rdata = 32'h0;
    step();
    imem_valid = 1'b0;
    step();
    check("ill_trap", {31'b0, trap}, 32'd1);
    check("ill_req", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    step();
    imem_valid = 1'b0;
    check("ill_sticky", {31'b0, trap}, 32'd1);
    check("ill_nowr", {31'b0, RegWrite}, 32'd0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;

    // sll (f3=001) is outside the subset
    imem_valid = 1'b1;
    imem_rdata = 32'h0020_9133;
    step();
    imem_valid = 1'b0;
    step();
    check("sll_trap", {31'b0, trap}, 32'd1);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;

    // reset during EXECUTE of addi x1 discards the write
    issue(32'h0050_0093, 32'h0, 0);
    check("mid_wr_before", {31'b0, RegWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wr_killed", {31'b0, RegWrite}, 32'd0);
    check("mid_pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_restart", imem_addr, 32'h0);
    check("mid_req", {31'b0, imem_req}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
- Multi-cycle control sequencer for the ALU/register-file datapath. It is the initiator side of that datapath's control interface.
- Fetches instructions from instruction memory over a req/valid handshake, decodes them, and drives ALUsrc/ALUctrl/RegWrite/rs1/rs2/rd/ImmOp.
- Consumes EQ to resolve branches and owns the PC.
- Supports the RV32I integer subset needed by the ALU; everything else traps.

Parameters:
- A_WIDTH, 5, register address width
- D_WIDTH, 32, data/instruction/PC width
- PC_RESET, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held high until accepted
- imem_addr  out  D_WIDTH  fetch address (= PC)
- imem_valid  in  1  instruction data valid; acceptance strobe
- imem_rdata  in  D_WIDTH  instruction word
- EQ  in  1  ALU equality flag (ALUop1 == ALUop2)
- ALUsrc  out  1  1 = ImmOp as operand 2, 0 = register
- ALUctrl  out  3  ALU operation
- RegWrite  out  1  register file write enable
- rs1, rs2, rd  out  A_WIDTH each  register addresses
- ImmOp  out  D_WIDTH  sign-extended immediate
- pc  out  D_WIDTH  current PC
- trap  out  1  sticky illegal-instruction/misaligned flag

Behaviour:
- Reset (async assert, sync deassert):
  - state=FETCH, pc=PC_RESET, IR=0, trap=0.
  - ALUsrc, ALUctrl, RegWrite, ImmOp all 0.
  - rs1, rs2, rd decode from IR=0, giving 0.
  - imem_req=0 while rst_n=0.
- FSM states: FETCH, DECODE, EXECUTE, TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc, both stable until imem_valid.
  - On imem_valid: IR<=imem_rdata, go to DECODE.
  - imem_valid in any other state is ignored.
- DECODE (1 cycle):
  - Classify IR. Legal: go to EXECUTE. Illegal: go to TRAP.
  - rs1/rs2/rd/ImmOp are driven from IR combinationally from this cycle until the next IR load.
- EXECUTE (1 cycle), ALU outputs valid:
  - OP (0110011), ALUsrc=0:
    - add: f3=000, f7=0000000 → ALUctrl=000
    - sub: f3=000, f7=0100000 → ALUctrl=001
    - and: f3=111 → ALUctrl=010
    - or: f3=110 → ALUctrl=011
    - slt: f3=010 → ALUctrl=101
    - Any other f3/f7 combination is illegal.
  - OP-IMM (0010011), ALUsrc=1, ImmOp = sext(IR[31:20]):
    - addi → ALUctrl=000
    - andi → ALUctrl=010
    - ori → ALUctrl=011
    - slti → ALUctrl=101
  - BRANCH (1100011), ALUsrc=0, ALUctrl=001, RegWrite=0, ImmOp = sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}):
    - beq (f3=000): taken when EQ=1.
    - bne (f3=001): taken when EQ=0.
  - For OP/OP-IMM: RegWrite=1 only in EXECUTE and only when rd≠0. The register file writes at the EXECUTE-ending edge.
  - PC update at the end of EXECUTE:
    - Branch taken: pc <= pc + ImmOp. Otherwise pc <= pc + 4.
    - Arithmetic is mod 2^32; wrap is silent.
    - A taken target with bit1 or bit0 set goes to TRAP instead; pc is unchanged.
  - Next state: FETCH.
- TRAP: trap=1, imem_req=0, RegWrite=0. Exit only via rst_n.
- RegWrite is 0 in all states except EXECUTE.
- ALUsrc/ALUctrl hold their decoded values outside EXECUTE. They are don't-care there, but must never produce a write.
- Latency: 3 cycles/instruction minimum (imem_valid in the first FETCH cycle), +1 per fetch wait cycle.
- Reset mid-operation: any in-flight instruction is discarded with no write. Fetch restarts at PC_RESET.

Decomposition:
- rv_ctrl_pkg: state enum, opcode constants (OPC_OP, OPC_OPIMM, OPC_BRANCH), ALUctrl encodings (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101).
- Sub-module rv_decode: purely combinational. Input IR; outputs legal, ALUsrc, ALUctrl, reg_wr, is_branch, br_ne, ImmOp, rs1/rs2/rd.
- The top module holds the FSM, PC and IR.

Test Plan:
- Reset, then imem_valid=1 with 0x00500093 (addi x1,x0,5) → in EXECUTE: RegWrite=1, rd=1, rs1=0, ALUsrc=1, ALUctrl=000, ImmOp=5. Next fetch imem_addr=4, 3 cycles after the first request.
- 0x40208133 (sub x2,x1,x2) → EXECUTE: ALUsrc=0, ALUctrl=001, rs1=1, rs2=2, rd=2, RegWrite=1.
- pc=0x10, fetch 0x00000463 (beq x0,x0,+8) with EQ=1 → RegWrite=0, ImmOp=8, next imem_addr=0x18. Repeat with EQ=0 → next imem_addr=0x14.
- Hold imem_valid low for 3 cycles → imem_req stays 1, imem_addr constant. Instruction completes 3 cycles late; no RegWrite pulse during the wait.
- Fetch 0x00000000 → TRAP, trap=1, imem_req=0 thereafter. Pulse rst_n low → trap=0, imem_addr=PC_RESET.
- addi with rd=0 (0x00500013) → RegWrite stays 0. Assert rst_n low during EXECUTE of addi x1 → no write pulse, restart at PC_RESET.
